// File: rtl/alu_control_unit.sv
// -----------------------------------------------------------------------------
// alu_control_unit
//
// Registered instruction-decode control block for a single-issue RISC-V
// datapath. The opcode drives the main datapath controls. The decoded aluOp,
// together with funct7/funct3, selects the 4-bit ALU operation. Every output
// is a flop, so a decode reaches the execute stage exactly one clock after the
// instruction is presented. A new instruction is accepted every cycle.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   instruction  in  32   instruction word (opcode [6:0], funct3 [14:12],
//                         funct7 [31:25])
//   in_valid     in   1   instruction is valid this cycle
//   out_valid    out  1   registered in_valid
//   aluSrc       out  1   ALU operand B is the immediate
//   memToReg     out  1   write-back data comes from memory
//   regWrite     out  1   register-file write enable
//   memRead      out  1   data-memory read enable
//   memWrite     out  1   data-memory write enable
//   branch       out  1   conditional branch instruction
//   aluOp        out  2   00 add, 01 sub/compare, 10 R-type decode, 11 unused
//   aluControl   out  4   0000 AND, 0001 OR, 0010 add, 0110 sub, 1111 invalid
//   illegal      out  1   opcode or R-type function is unsupported
// -----------------------------------------------------------------------------
module alu_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic        out_valid,
    output logic        aluSrc,
    output logic        memToReg,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        branch,
    output logic [1:0]  aluOp,
    output logic [3:0]  aluControl,
    output logic        illegal
);

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    // aluOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type function fields
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // aluControl encodings
    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_INV = 4'b1111;

    // Main datapath controls, packed in the documented field order
    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    // Instruction fields
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_fields_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];
    // Register and immediate fields play no part in control decode
    assign unused_fields_s = ^{instruction[24:15], instruction[11:7]};

    // Combinational decode results
    ctrl_t      main_ctrl_s;
    logic       opc_illegal_s;
    logic [3:0] alu_ctrl_s;
    logic       fn_illegal_s;

    // Next-state values and registered state
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic [3:0] alu_ctrl_d;
    logic [3:0] alu_ctrl_q;
    logic       illegal_d;
    logic       illegal_q;
    logic       valid_d;
    logic       valid_q;

    // Main decode from the opcode. Only exact matches of the four supported
    // opcodes fall into a decode arm; anything else, including unknown bits,
    // lands in the default arm and is treated as illegal with every enable 0.
    always_comb begin
        main_ctrl_s   = CTRL_NONE;
        opc_illegal_s = 1'b0;
        case (opcode_s)
            OPC_RTYPE: main_ctrl_s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_RTYPE};
            // Load/store width in funct3 is deliberately ignored
            OPC_LOAD:  main_ctrl_s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
            OPC_STORE: main_ctrl_s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
            OPC_BEQ:   main_ctrl_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
            default: begin
                main_ctrl_s   = CTRL_NONE;
                opc_illegal_s = 1'b1;
            end
        endcase
    end

    // ALU decode from the decoded aluOp and the R-type function fields.
    // An unsupported R-type combination reports invalid and raises illegal.
    always_comb begin
        alu_ctrl_s   = ALUC_INV;
        fn_illegal_s = 1'b0;
        case (main_ctrl_s.alu_op)
            ALUOP_ADD: alu_ctrl_s = ALUC_ADD;
            ALUOP_SUB: alu_ctrl_s = ALUC_SUB;
            ALUOP_RTYPE: begin
                case ({funct7_s, funct3_s})
                    {F7_BASE, F3_ADD}: alu_ctrl_s = ALUC_ADD;
                    {F7_ALT,  F3_ADD}: alu_ctrl_s = ALUC_SUB;
                    {F7_BASE, F3_AND}: alu_ctrl_s = ALUC_AND;
                    {F7_BASE, F3_OR}:  alu_ctrl_s = ALUC_OR;
                    default: begin
                        alu_ctrl_s   = ALUC_INV;
                        fn_illegal_s = 1'b1;
                    end
                endcase
            end
            default: alu_ctrl_s = ALUC_INV;
        endcase
    end

    // Next-state selection: a valid instruction loads its decode with the
    // illegal overrides applied; otherwise the flops load an all-zero bubble.
    always_comb begin
        ctrl_d     = CTRL_NONE;
        alu_ctrl_d = 4'b0000;
        illegal_d  = 1'b0;
        valid_d    = 1'b0;
        if (in_valid == 1'b1) begin
            valid_d    = 1'b1;
            ctrl_d     = main_ctrl_s;
            alu_ctrl_d = alu_ctrl_s;
            illegal_d  = 1'b0;
            if (opc_illegal_s) begin
                // Unknown opcode: no architectural effect, ALU marked invalid
                alu_ctrl_d = ALUC_INV;
                illegal_d  = 1'b1;
            end else if (fn_illegal_s) begin
                // Unsupported R-type function: suppress the register write
                ctrl_d.reg_write = 1'b0;
                illegal_d        = 1'b1;
            end else begin
                illegal_d = 1'b0;
            end
        end else begin
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NONE;
            alu_ctrl_d = 4'b0000;
            illegal_d  = 1'b0;
        end
    end

    // Output registers; reset clears every output without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_NONE;
            alu_ctrl_q <= 4'b0000;
            illegal_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            alu_ctrl_q <= alu_ctrl_d;
            illegal_q  <= illegal_d;
            valid_q    <= valid_d;
        end
    end

    assign out_valid  = valid_q;
    assign aluSrc     = ctrl_q.alu_src;
    assign memToReg   = ctrl_q.mem_to_reg;
    assign regWrite   = ctrl_q.reg_write;
    assign memRead    = ctrl_q.mem_read;
    assign memWrite   = ctrl_q.mem_write;
    assign branch     = ctrl_q.branch;
    assign aluOp      = ctrl_q.alu_op;
    assign aluControl = alu_ctrl_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_control_unit
//
// Self-checking bench for alu_control_unit. A reference model classifies each
// instruction and looks up its expected control word; the expected word is
// delayed by one clock and compared with the DUT on every falling edge.
// Directed vectors with hand-computed expectations pin both the DUT and the
// model, then a long randomized run covers the remaining space.
//
// Compared word layout (14 bits):
//   {out_valid, aluSrc, memToReg, regWrite, memRead, memWrite, branch,
//    aluOp[1:0], aluControl[3:0], illegal}
// -----------------------------------------------------------------------------
module tb_alu_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        in_valid;
    logic        out_valid;
    logic        aluSrc;
    logic        memToReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic [1:0]  aluOp;
    logic [3:0]  aluControl;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    logic        chk_en = 1'b0;
    logic [13:0] exp_q  = 14'h0;
    logic [13:0] dut_vec;

    alu_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .aluSrc     (aluSrc),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .branch     (branch),
        .aluOp      (aluOp),
        .aluControl (aluControl),
        .illegal    (illegal)
    );

    assign dut_vec = {out_valid, aluSrc, memToReg, regWrite, memRead, memWrite,
                      branch, aluOp, aluControl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction classes used by the reference model
    localparam int C_LOAD = 0, C_STORE = 1, C_BEQ = 2, C_ADD = 3, C_SUB = 4,
                   C_AND = 5, C_OR = 6, C_BADR = 7, C_BADOP = 8;

    function automatic int classify(input logic [31:0] ins);
        logic [9:0] fn;
        fn = {ins[31:25], ins[14:12]};
        if (ins[6:0] == 7'h03) return C_LOAD;
        if (ins[6:0] == 7'h23) return C_STORE;
        if (ins[6:0] == 7'h63) return C_BEQ;
        if (ins[6:0] == 7'h33) begin
            if (fn == 10'h000) return C_ADD;
            if (fn == 10'h100) return C_SUB;
            if (fn == 10'h007) return C_AND;
            if (fn == 10'h006) return C_OR;
            return C_BADR;
        end
        return C_BADOP;
    endfunction

    // Expected output word for one presented instruction
    function automatic logic [13:0] model(input logic v, input logic [31:0] ins);
        logic [7:0] ctl;
        logic [3:0] aluc;
        logic       ill;
        if (v !== 1'b1) return 14'h0;
        ill = 1'b0;
        case (classify(ins))
            C_LOAD:  begin ctl = 8'b11110000; aluc = 4'b0010; end
            C_STORE: begin ctl = 8'b10001000; aluc = 4'b0010; end
            C_BEQ:   begin ctl = 8'b00000101; aluc = 4'b0110; end
            C_ADD:   begin ctl = 8'b00100010; aluc = 4'b0010; end
            C_SUB:   begin ctl = 8'b00100010; aluc = 4'b0110; end
            C_AND:   begin ctl = 8'b00100010; aluc = 4'b0000; end
            C_OR:    begin ctl = 8'b00100010; aluc = 4'b0001; end
            C_BADR:  begin ctl = 8'b00000010; aluc = 4'b1111; ill = 1'b1; end
            default: begin ctl = 8'b00000000; aluc = 4'b1111; ill = 1'b1; end
        endcase
        return {1'b1, ctl, aluc, ill};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs, one clock behind the inputs, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 14'h0;
        else        exp_q <= model(in_valid, instruction);
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) check("cycle", dut_vec, exp_q);
    end

    // Drive at a falling edge and wait for the next one
    task automatic apply(input logic v, input logic [31:0] ins);
        in_valid    = v;
        instruction = ins;
        @(negedge clk);
    endtask

    logic [31:0] dir_ins [0:8];
    logic [13:0] dir_exp [0:8];

    initial begin
        logic [31:0] r;
        logic        v;
        int          pick;

        dir_ins[0] = 32'h00512003; dir_exp[0] = 14'b1_11110000_0010_0;
        dir_ins[1] = 32'h000122A3; dir_exp[1] = 14'b1_10001000_0010_0;
        dir_ins[2] = 32'h00104263; dir_exp[2] = 14'b1_00000101_0110_0;
        dir_ins[3] = 32'h00208033; dir_exp[3] = 14'b1_00100010_0010_0;
        dir_ins[4] = 32'h41FF8FB3; dir_exp[4] = 14'b1_00100010_0110_0;
        dir_ins[5] = 32'h0056F033; dir_exp[5] = 14'b1_00100010_0000_0;
        dir_ins[6] = 32'h0178E1B3; dir_exp[6] = 14'b1_00100010_0001_0;
        dir_ins[7] = 32'hFFFFFFFF; dir_exp[7] = 14'b1_00000000_1111_1;
        dir_ins[8] = 32'h00209033; dir_exp[8] = 14'b1_00000010_1111_1;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec, 14'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed vectors back-to-back, one per cycle
        for (int i = 0; i < 9; i++) begin
            check("model_pin", model(1'b1, dir_ins[i]), dir_exp[i]);
            apply(1'b1, dir_ins[i]);
            check("directed", dut_vec, dir_exp[i]);
        end

        // Bubble
        check("model_bubble", model(1'b0, 32'h00512003), 14'h0);
        apply(1'b0, 32'h00512003);
        check("bubble", dut_vec, 14'h0);

        // Asynchronous reset between edges with an instruction in flight
        apply(1'b1, 32'h00512003);
        check("pre_reset", dut_vec, 14'b1_11110000_0010_0);
        in_valid    = 1'b1;
        instruction = 32'h00104263;
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_vec, 14'h0);
        @(negedge clk);
        check("reset_discard", dut_vec, 14'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("after_release", dut_vec, 14'h0);
        apply(1'b1, 32'h000122A3);
        check("first_after_reset", dut_vec, 14'b1_10001000_0010_0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom;
            pick = $urandom_range(0, 9);
            v    = ($urandom_range(0, 7) != 0);
            case (pick)
                0, 1: r[6:0] = 7'h03;
                2, 3: r[6:0] = 7'h23;
                4:    r[6:0] = 7'h63;
                5, 6, 7: begin
                    r[6:0] = 7'h33;
                    if ($urandom_range(0, 3) != 0) begin
                        r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
                        case ($urandom_range(0, 3))
                            0:       r[14:12] = 3'b000;
                            1:       r[14:12] = 3'b110;
                            2:       r[14:12] = 3'b111;
                            default: r[14:12] = 3'($urandom_range(0, 7));
                        endcase
                    end
                end
                default: ;
            endcase
            in_valid    = v;
            instruction = r;
            if ((i % 700) == 350) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
